// File: rtl/seq_miter_monitor.sv
// -----------------------------------------------------------------------------
// seq_miter_monitor
//
// Sequential miter checker. It compares the golden and revised output vectors
// of two circuit versions, one vector per accepted cycle, across a stimulus
// stream.
//
// A per-bit care mask marks don't-care outputs. The block reports:
//   - the first failing vector (its index and its differing bits),
//   - the number of vectors accepted,
//   - the number of failing vectors.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   start      : pulse, clears results and begins a new check run
//   in_valid   : golden/revised/care_mask/last are valid this cycle
//   golden     : reference circuit outputs        [WIDTH]
//   revised    : revised circuit outputs          [WIDTH]
//   care_mask  : 1 = bit compared, 0 = don't-care [WIDTH]
//   last       : marks the final vector of the stream (with in_valid)
//   busy       : a run is in progress
//   done       : run finished (completed or stopped on failure)
//   fail       : sticky, at least one masked mismatch in this run
//   fail_idx   : 0-based index of the first failing vector [CNT_W]
//   fail_bits  : masked difference of the first failing vector [WIDTH]
//   vec_cnt    : vectors accepted this run, saturating [CNT_W]
//   mis_cnt    : failing vectors this run, saturating  [CNT_W]
//
// Every output is registered. Nothing passes combinationally from an input to
// an output.
// -----------------------------------------------------------------------------
module seq_miter_monitor #(
   parameter int unsigned WIDTH        = 2,
   parameter int unsigned CNT_W        = 16,
   parameter bit          STOP_ON_FAIL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] golden,
   input  logic [WIDTH-1:0] revised,
   input  logic [WIDTH-1:0] care_mask,
   input  logic             last,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] fail_idx,
   output logic [WIDTH-1:0] fail_bits,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] mis_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10,
      ST_FAIL = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] BITS_ZERO = {WIDTH{1'b0}};

   // Bits that differ between the two versions, restricted to the cared bits.
   function automatic logic [WIDTH-1:0] masked_diff(
      input logic [WIDTH-1:0] g,
      input logic [WIDTH-1:0] r,
      input logic [WIDTH-1:0] m
   );
      return (g ^ r) & m;
   endfunction

   // Counter increment that holds at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] res;
      if (v == CNT_MAX) begin
         res = CNT_MAX;
      end else begin
         res = v + CNT_ONE;
      end
      return res;
   endfunction

   state_t           state_r;
   state_t           state_next_s;
   logic             busy_r;
   logic             done_r;
   logic             fail_r;
   logic             fail_next_s;
   logic [CNT_W-1:0] fail_idx_r;
   logic [CNT_W-1:0] fail_idx_next_s;
   logic [WIDTH-1:0] fail_bits_r;
   logic [WIDTH-1:0] fail_bits_next_s;
   logic [CNT_W-1:0] vec_cnt_r;
   logic [CNT_W-1:0] vec_cnt_next_s;
   logic [CNT_W-1:0] mis_cnt_r;
   logic [CNT_W-1:0] mis_cnt_next_s;

   logic             accept_s;
   logic [WIDTH-1:0] diff_s;
   logic             mismatch_s;

   // A vector counts only while running. A start in the same cycle drops it.
   assign accept_s   = (state_r == ST_RUN) && in_valid && !start;
   assign diff_s     = masked_diff(golden, revised, care_mask);
   assign mismatch_s = |diff_s;

   // Next-state and next-result computation for the run controller.
   always_comb begin
      state_next_s     = state_r;
      fail_next_s      = fail_r;
      fail_idx_next_s  = fail_idx_r;
      fail_bits_next_s = fail_bits_r;
      vec_cnt_next_s   = vec_cnt_r;
      mis_cnt_next_s   = mis_cnt_r;

      if (start) begin
         // start restarts from any state and wipes the previous results.
         state_next_s     = ST_RUN;
         fail_next_s      = 1'b0;
         fail_idx_next_s  = CNT_ZERO;
         fail_bits_next_s = BITS_ZERO;
         vec_cnt_next_s   = CNT_ZERO;
         mis_cnt_next_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s = ST_IDLE;
            end
            ST_RUN: begin
               // A stop on mismatch takes priority over last on the same vector.
               if (accept_s && mismatch_s && STOP_ON_FAIL) begin
                  state_next_s = ST_FAIL;
               end else if (accept_s && last) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            ST_DONE: begin
               state_next_s = ST_DONE;
            end
            ST_FAIL: begin
               state_next_s = ST_FAIL;
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase

         if (accept_s) begin
            vec_cnt_next_s = sat_inc(vec_cnt_r);
            if (mismatch_s) begin
               mis_cnt_next_s = sat_inc(mis_cnt_r);
               // Only the first failure of a run is captured. The index is
               // the count before this vector, so it is 0-based (and it
               // saturates together with the counter).
               if (!fail_r) begin
                  fail_next_s      = 1'b1;
                  fail_idx_next_s  = vec_cnt_r;
                  fail_bits_next_s = diff_s;
               end else begin
                  fail_next_s      = fail_r;
                  fail_idx_next_s  = fail_idx_r;
                  fail_bits_next_s = fail_bits_r;
               end
            end else begin
               mis_cnt_next_s = mis_cnt_r;
            end
         end else begin
            vec_cnt_next_s = vec_cnt_r;
            mis_cnt_next_s = mis_cnt_r;
         end
      end
   end

   // State and result registers. busy/done come from the next state so that
   // they line up with state_r without any output decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         fail_r      <= 1'b0;
         fail_idx_r  <= CNT_ZERO;
         fail_bits_r <= BITS_ZERO;
         vec_cnt_r   <= CNT_ZERO;
         mis_cnt_r   <= CNT_ZERO;
      end else begin
         state_r     <= state_next_s;
         busy_r      <= (state_next_s == ST_RUN);
         done_r      <= (state_next_s == ST_DONE) || (state_next_s == ST_FAIL);
         fail_r      <= fail_next_s;
         fail_idx_r  <= fail_idx_next_s;
         fail_bits_r <= fail_bits_next_s;
         vec_cnt_r   <= vec_cnt_next_s;
         mis_cnt_r   <= mis_cnt_next_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign fail      = fail_r;
   assign fail_idx  = fail_idx_r;
   assign fail_bits = fail_bits_r;
   assign vec_cnt   = vec_cnt_r;
   assign mis_cnt   = mis_cnt_r;

endmodule
